// File: rtl/memory_access_pkg.sv
// Shared MEM-stage definitions: data width, memory opcodes and the FSM
// state encoding that the hazard unit decodes.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef MIPS_LW
`define MIPS_LW 6'b100011
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

package memory_access_pkg;

  localparam int DATA_SIZE = `DATA_SIZE;

  localparam logic [5:0] OP_LW = `MIPS_LW;
  localparam logic [5:0] OP_SW = `MIPS_SW;

  // Encodings exported so other pipeline blocks can decode the MEM state
  localparam logic MEM_STATE_IDLE = 1'b0;
  localparam logic MEM_STATE_WAIT = 1'b1;

  typedef enum logic {
    ST_IDLE = MEM_STATE_IDLE,
    ST_WAIT = MEM_STATE_WAIT
  } mem_state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/memory_access_timeout_counter.sv
// Counts request cycles without an acknowledge; expired flags the last
// allowed cycle so the FSM can abort on that same cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count up while enabled; clear takes priority
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: passes ALU results to writeback and performs lw/sw
// over a req/ack data-memory handshake with misalign and timeout drops.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass through in one cycle
// WAIT  | dmem_req held high, waiting for dmem_ack or the timeout
module memory_access
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 EX_MEM_sign_c,
  input  logic                 EX_MEM_zero_c,
  input  logic                 EX_MEM_overflow_c,
  input  logic                 EX_MEM_carry_c,
  input  logic [DATA_SIZE-1:0] EX_MEM_result,
  input  logic [DATA_SIZE-1:0] EX_MEM_store_data,
  input  logic [4:0]           EX_MEM_dest,
  input  logic [5:0]           EX_MEM_op,
  input  logic [1:0]           EX_MEM_instruc_type,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DATA_SIZE-1:0] dmem_addr,
  output logic [DATA_SIZE-1:0] dmem_wdata,
  input  logic [DATA_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 MEM_WB_sign_c,
  output logic                 MEM_WB_zero_c,
  output logic                 MEM_WB_overflow_c,
  output logic                 MEM_WB_carry_c,
  output logic [DATA_SIZE-1:0] MEM_WB_result,
  output logic [DATA_SIZE-1:0] MEM_WB_data,
  output logic [4:0]           MEM_WB_dest,
  output logic [5:0]           MEM_WB_op,
  output logic [1:0]           MEM_WB_instruc_type,
  output logic                 MEM_stall,
  output logic                 MEM_fault,
  output logic                 MEM_misalign
);

  mem_state_t r_state;
  mem_state_t w_state_next;

  logic w_is_mem;
  logic w_misaligned;
  logic w_start;
  logic w_load;
  logic w_hold;
  logic w_drop_misalign;
  logic w_drop_timeout;
  logic w_stall;
  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_expired;
  logic [DATA_SIZE-1:0] w_load_data;

  logic                 r_req;
  logic                 r_we;
  logic [DATA_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0] r_wdata;
  logic                 r_wb_sign;
  logic                 r_wb_zero;
  logic                 r_wb_overflow;
  logic                 r_wb_carry;
  logic [DATA_SIZE-1:0] r_wb_result;
  logic [DATA_SIZE-1:0] r_wb_data;
  logic [4:0]           r_wb_dest;
  logic [5:0]           r_wb_op;
  logic [1:0]           r_wb_type;
  logic                 r_fault;
  logic                 r_misalign;

  assign w_is_mem     = is_mem_op(EX_MEM_op);
  assign w_misaligned = (EX_MEM_result[1:0] != 2'b00);

  // Only a completed load in WAIT forwards memory data; everything else writes 0
  assign w_load_data = ((r_state == ST_WAIT) && (EX_MEM_op == OP_LW)) ? dmem_rdata : '0;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode; ack wins over an expiring timeout
  always_comb begin
    w_state_next    = r_state;
    w_start         = 1'b0;
    w_load          = 1'b0;
    w_hold          = 1'b0;
    w_drop_misalign = 1'b0;
    w_drop_timeout  = 1'b0;
    w_stall         = 1'b0;
    w_cnt_clear     = 1'b0;
    w_cnt_enable    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clear = 1'b1;
        if (w_is_mem) begin
          if (w_misaligned) begin
            w_drop_misalign = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_stall      = 1'b1;
            w_state_next = ST_WAIT;
          end
        end else begin
          w_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          w_load       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_expired) begin
          w_drop_timeout = 1'b1;
          w_state_next   = ST_IDLE;
        end else begin
          w_hold       = 1'b1;
          w_stall      = 1'b1;
          w_cnt_enable = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // MEM/WB pipeline register: load on completion, otherwise emit a bubble
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wb_sign     <= 1'b0;
      r_wb_zero     <= 1'b0;
      r_wb_overflow <= 1'b0;
      r_wb_carry    <= 1'b0;
      r_wb_result   <= '0;
      r_wb_data     <= '0;
      r_wb_dest     <= '0;
      r_wb_op       <= '0;
      r_wb_type     <= 2'b00;
    end else if (w_load) begin
      r_wb_sign     <= EX_MEM_sign_c;
      r_wb_zero     <= EX_MEM_zero_c;
      r_wb_overflow <= EX_MEM_overflow_c;
      r_wb_carry    <= EX_MEM_carry_c;
      r_wb_result   <= EX_MEM_result;
      r_wb_data     <= w_load_data;
      r_wb_dest     <= EX_MEM_dest;
      r_wb_op       <= EX_MEM_op;
      r_wb_type     <= EX_MEM_instruc_type;
    end else if (w_start || w_hold || w_drop_misalign || w_drop_timeout) begin
      r_wb_type <= 2'b00;
    end
  end

  // Data-memory request: captured at start, held through WAIT, dropped on ack or timeout
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= (EX_MEM_op == OP_SW);
      r_addr  <= EX_MEM_result;
      r_wdata <= EX_MEM_store_data;
    end else if (w_load || w_drop_timeout) begin
      r_req <= 1'b0;
    end
  end

  // Single-cycle fault and misalign pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fault    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_fault    <= w_drop_timeout;
      r_misalign <= w_drop_misalign;
    end
  end

  assign dmem_req            = r_req;
  assign dmem_we             = r_we;
  assign dmem_addr           = r_addr;
  assign dmem_wdata          = r_wdata;
  assign MEM_WB_sign_c       = r_wb_sign;
  assign MEM_WB_zero_c       = r_wb_zero;
  assign MEM_WB_overflow_c   = r_wb_overflow;
  assign MEM_WB_carry_c      = r_wb_carry;
  assign MEM_WB_result       = r_wb_result;
  assign MEM_WB_data         = r_wb_data;
  assign MEM_WB_dest         = r_wb_dest;
  assign MEM_WB_op           = r_wb_op;
  assign MEM_WB_instruc_type = r_wb_type;
  assign MEM_stall           = w_stall;
  assign MEM_fault           = r_fault;
  assign MEM_misalign        = r_misalign;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for the MEM stage: directed scenarios followed by
// random traffic against a transaction-level model with a word memory.
module tb_memory_access;

  localparam int TIMEOUT = 16;
  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        EX_MEM_sign_c, EX_MEM_zero_c, EX_MEM_overflow_c, EX_MEM_carry_c;
  logic [31:0] EX_MEM_result, EX_MEM_store_data;
  logic [4:0]  EX_MEM_dest;
  logic [5:0]  EX_MEM_op;
  logic [1:0]  EX_MEM_instruc_type;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        MEM_WB_sign_c, MEM_WB_zero_c, MEM_WB_overflow_c, MEM_WB_carry_c;
  logic [31:0] MEM_WB_result, MEM_WB_data;
  logic [4:0]  MEM_WB_dest;
  logic [5:0]  MEM_WB_op;
  logic [1:0]  MEM_WB_instruc_type;
  logic        MEM_stall, MEM_fault, MEM_misalign;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_model [logic [31:0]];

  always #5 clock = ~clock;

  memory_access #(.TIMEOUT(TIMEOUT)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .EX_MEM_sign_c       (EX_MEM_sign_c),
    .EX_MEM_zero_c       (EX_MEM_zero_c),
    .EX_MEM_overflow_c   (EX_MEM_overflow_c),
    .EX_MEM_carry_c      (EX_MEM_carry_c),
    .EX_MEM_result       (EX_MEM_result),
    .EX_MEM_store_data   (EX_MEM_store_data),
    .EX_MEM_dest         (EX_MEM_dest),
    .EX_MEM_op           (EX_MEM_op),
    .EX_MEM_instruc_type (EX_MEM_instruc_type),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .MEM_WB_sign_c       (MEM_WB_sign_c),
    .MEM_WB_zero_c       (MEM_WB_zero_c),
    .MEM_WB_overflow_c   (MEM_WB_overflow_c),
    .MEM_WB_carry_c      (MEM_WB_carry_c),
    .MEM_WB_result       (MEM_WB_result),
    .MEM_WB_data         (MEM_WB_data),
    .MEM_WB_dest         (MEM_WB_dest),
    .MEM_WB_op           (MEM_WB_op),
    .MEM_WB_instruc_type (MEM_WB_instruc_type),
    .MEM_stall           (MEM_stall),
    .MEM_fault           (MEM_fault),
    .MEM_misalign        (MEM_misalign)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    if (mem_model.exists(addr)) return mem_model[addr];
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] dest, input logic [1:0] typ, input logic [3:0] flg);
    EX_MEM_op           = op;
    EX_MEM_result       = res;
    EX_MEM_store_data   = sd;
    EX_MEM_dest         = dest;
    EX_MEM_instruc_type = typ;
    {EX_MEM_sign_c, EX_MEM_zero_c, EX_MEM_overflow_c, EX_MEM_carry_c} = flg;
  endtask

  task automatic drive_nop();
    drive(6'd0, 32'd0, 32'd0, 5'd0, 2'b00, 4'd0);
  endtask

  function automatic logic [3:0] wb_flags();
    return {MEM_WB_sign_c, MEM_WB_zero_c, MEM_WB_overflow_c, MEM_WB_carry_c};
  endfunction

  // One instruction through MEM. ack_after = number of req cycles up to and
  // including the ack; 0 (or > TIMEOUT) means memory never answers.
  task automatic do_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] dest, input logic [1:0] typ, input logic [3:0] flg,
                       input int ack_after);
    logic is_mem;
    logic [31:0] exp_data;
    is_mem = (op == LW) || (op == SW);
    drive(op, res, sd, dest, typ, flg);
    #1;
    if (!is_mem) begin
      check("pass_stall", MEM_stall, 1'b0);
      step();
      check("pass_result", MEM_WB_result, res);
      check("pass_dest_op_type", {MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type}, {dest, op, typ});
      check("pass_data_flags", {MEM_WB_data, wb_flags()}, {32'd0, flg});
      check("pass_req", dmem_req, 1'b0);
    end else if (res[1:0] != 2'b00) begin
      check("mis_stall", MEM_stall, 1'b0);
      step();
      check("mis_pulse", MEM_misalign, 1'b1);
      check("mis_req_type", {dmem_req, MEM_WB_instruc_type}, 3'b000);
      drive_nop();
      step();
      check("mis_pulse_end", {MEM_misalign, dmem_req}, 2'b00);
    end else begin
      check("mem_stall_idle", MEM_stall, 1'b1);
      check("mem_req_gap", dmem_req, 1'b0);
      for (int k = 1; k <= TIMEOUT; k++) begin
        step();
        check("mem_req", dmem_req, 1'b1);
        check("mem_we_addr_wdata", {dmem_we, dmem_addr, dmem_wdata}, {(op == SW), res, sd});
        check("mem_bubble", MEM_WB_instruc_type, 2'b00);
        if (k == ack_after) begin
          exp_data   = (op == LW) ? mem_read(res) : 32'd0;
          dmem_ack   = 1'b1;
          dmem_rdata = (op == LW) ? mem_read(res) : $urandom;
          #1;
          check("ack_stall", MEM_stall, 1'b0);
          step();
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          check("done_result", MEM_WB_result, res);
          check("done_data", MEM_WB_data, exp_data);
          check("done_dest_op_type", {MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type}, {dest, op, typ});
          check("done_flags_req", {wb_flags(), dmem_req}, {flg, 1'b0});
          if (op == SW) mem_model[res] = sd;
          break;
        end else if (k == TIMEOUT) begin
          #1;
          check("to_stall", MEM_stall, 1'b0);
          step();
          check("to_fault", MEM_fault, 1'b1);
          check("to_req_type", {dmem_req, MEM_WB_instruc_type}, 3'b000);
          drive_nop();
          step();
          check("to_fault_end", {MEM_fault, dmem_req}, 2'b00);
        end else begin
          #1;
          check("wait_stall", MEM_stall, 1'b1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] addr;
    int          kind;

    reset_n    = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    drive_nop();
    step();
    step();
    check("rst_wb", {MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, wb_flags()}, 128'd0);
    check("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 66'd0);
    check("rst_pulses_stall", {MEM_fault, MEM_misalign, MEM_stall}, 3'b000);
    reset_n = 1'b1;
    step();

    do_op(6'h00, 32'h0000_0010, 32'd0, 5'd5, 2'b10, 4'b0000, 0);
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_op(LW, 32'h0000_0100, 32'd0, 5'd8, 2'b10, 4'b0100, 1);
    do_op(SW, 32'h0000_0104, 32'h0000_1234, 5'd0, 2'b01, 4'b0001, 4);
    do_op(LW, 32'h0000_0104, 32'd0, 5'd9, 2'b10, 4'b1000, 2);
    do_op(LW, 32'h0000_0102, 32'd0, 5'd3, 2'b10, 4'b0000, 1);
    do_op(LW, 32'h0000_0108, 32'd0, 5'd4, 2'b10, 4'b0000, 0);
    do_op(6'h08, 32'h0000_0055, 32'd0, 5'd7, 2'b10, 4'b0010, 0);

    // Reset asserted during the third WAIT cycle of a load
    drive(LW, 32'h0000_0200, 32'd0, 5'd6, 2'b10, 4'b1111);
    step();
    step();
    step();
    check("rstw_req_before", dmem_req, 1'b1);
    reset_n = 1'b0;
    step();
    check("rstw_req", dmem_req, 1'b0);
    check("rstw_wb", {MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, wb_flags()}, 128'd0);
    check("rstw_pulses", {MEM_fault, MEM_misalign}, 2'b00);
    reset_n = 1'b1;
    drive_nop();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_ack = 1'b0;
    check("late_ack_wb", {MEM_WB_data, MEM_WB_result, MEM_WB_instruc_type}, 66'd0);
    check("late_ack_req_stall", {dmem_req, MEM_stall}, 2'b00);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      addr = 32'h0000_0400 + 32'($urandom_range(0, 7)) * 4;
      if (kind < 4) begin
        op = 6'($urandom_range(0, 63));
        if (op == LW || op == SW) op = 6'h00;
        do_op(op, $urandom, $urandom, 5'($urandom), 2'($urandom), 4'($urandom), 0);
      end else if (kind < 6) begin
        do_op(LW, addr, $urandom, 5'($urandom), 2'b10, 4'($urandom), $urandom_range(1, 5));
      end else if (kind < 9) begin
        do_op(SW, addr, $urandom, 5'($urandom), 2'($urandom), 4'($urandom), $urandom_range(1, 5));
      end else begin
        do_op(($urandom_range(0, 1) != 0) ? LW : SW, addr | 32'($urandom_range(1, 3)),
              $urandom, 5'($urandom), 2'b10, 4'($urandom), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
